access_arbiter_param: RTL and testbench

ACCESS_ARBITER_PARAM -- requirements
Module: access_arbiter_param

---
 rtl/access_arbiter_param.sv | 178 +++++++++++++++++
 tb/tb_access_arbiter_param.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/access_arbiter_param.sv
// Access arbiter: master 0 has absolute priority and may preempt one
// round-robin owner; the preempted owner is resumed when master 0 is done.
// Optional hold timeout forces a release of a stuck owner.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no grant outstanding
// GRANT   | owner holds the resource (owner may be master 0)
// PREEMPT | master 0 holds the resource, suspended owner waits to resume
module access_arbiter_param #(
    parameter int N_MASTERS = 3,
    parameter int CNT_W     = 8,
    parameter int TIMEOUT   = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_MASTERS-1:0]         req,
    input  logic [N_MASTERS-1:0]         done,
    output logic [N_MASTERS-1:0]         grant,
    output logic [$clog2(N_MASTERS)-1:0] owner_id,
    output logic [1:0]                   state,
    output logic [CNT_W-1:0]             nb_interrupts,
    output logic                         timeout_err
);

    localparam int ID_W      = $clog2(N_MASTERS);
    localparam int HOLD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int HOLD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_GRANT   = 2'b01,
        S_PREEMPT = 2'b10
    } state_t;

    state_t              state_q, state_n;
    logic [ID_W-1:0]     owner_n;
    logic [ID_W-1:0]     rr_q, rr_n;
    logic [ID_W-1:0]     susp_q, susp_n;
    logic [HOLD_W-1:0]   hold_q, hold_n;
    logic [CNT_W-1:0]    cnt_n;
    logic                terr_n;
    logic [N_MASTERS-1:0] grant_n;
    logic [ID_W:0]       pick;
    logic                hold_hit;
    logic                arb;
    logic                arb_prio;

    // First requester among masters 1..N-1 starting at the pointer, with wrap.
    // Master 0 is never part of the round-robin ring.
    function automatic logic [ID_W:0] rr_pick(input logic [N_MASTERS-1:0] r,
                                              input logic [ID_W-1:0]      start);
        logic [ID_W:0] res;
        res = '0;
        for (int i = 0; i < N_MASTERS - 1; i++) begin
            int idx;
            idx = int'(start) + i;
            if (idx > N_MASTERS - 1)
                idx = idx - (N_MASTERS - 1);
            if (!res[ID_W] && r[ID_W'(idx)])
                res = {1'b1, ID_W'(idx)};
        end
        return res;
    endfunction

    function automatic logic [ID_W-1:0] rr_after(input logic [ID_W-1:0] k);
        return (k == ID_W'(N_MASTERS - 1)) ? ID_W'(1) : k + ID_W'(1);
    endfunction

    assign pick     = rr_pick(req, rr_q);
    assign hold_hit = (TIMEOUT > 0) && (hold_q == HOLD_W'(HOLD_LAST));
    assign state    = state_q;

    // Next-state, next-owner and bookkeeping decisions.
    always_comb begin
        state_n  = state_q;
        owner_n  = owner_id;
        rr_n     = rr_q;
        susp_n   = susp_q;
        hold_n   = hold_q;
        cnt_n    = nb_interrupts;
        terr_n   = 1'b0;
        arb      = 1'b0;
        arb_prio = 1'b1;

        case (state_q)
            S_IDLE: begin
                arb = 1'b1;
            end
            S_GRANT: begin
                if (done[owner_id]) begin
                    arb = 1'b1;
                end else if (hold_hit) begin
                    state_n = S_IDLE;
                    owner_n = '0;
                    susp_n  = '0;
                    terr_n  = 1'b1;
                end else if (owner_id != '0 && req[0]) begin
                    state_n = S_PREEMPT;
                    susp_n  = owner_id;
                    owner_n = '0;
                    hold_n  = '0;
                    if (nb_interrupts != {CNT_W{1'b1}})
                        cnt_n = nb_interrupts + 1'b1;
                end else if (TIMEOUT > 0) begin
                    hold_n = hold_q + 1'b1;
                end
            end
            S_PREEMPT: begin
                if (done[0]) begin
                    susp_n = '0;
                    if (req[susp_q]) begin
                        state_n = S_GRANT;
                        owner_n = susp_q;
                        hold_n  = '0;
                    end else begin
                        arb      = 1'b1;
                        arb_prio = 1'b0;
                    end
                end else if (hold_hit) begin
                    state_n = S_IDLE;
                    owner_n = '0;
                    susp_n  = '0;
                    terr_n  = 1'b1;
                end else if (TIMEOUT > 0) begin
                    hold_n = hold_q + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                owner_n = '0;
            end
        endcase

        // Shared arbitration; the priority master is skipped right after a preemption ends.
        if (arb) begin
            if (arb_prio && req[0]) begin
                state_n = S_GRANT;
                owner_n = '0;
                hold_n  = '0;
            end else if (pick[ID_W]) begin
                state_n = S_GRANT;
                owner_n = pick[ID_W-1:0];
                rr_n    = rr_after(pick[ID_W-1:0]);
                hold_n  = '0;
            end else begin
                state_n = S_IDLE;
                owner_n = '0;
            end
        end

        grant_n = (state_n != S_IDLE) ? (N_MASTERS'(1) << owner_n) : '0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            owner_id      <= '0;
            grant         <= '0;
            rr_q          <= ID_W'(1);
            susp_q        <= '0;
            hold_q        <= '0;
            nb_interrupts <= '0;
            timeout_err   <= 1'b0;
        end else begin
            state_q       <= state_n;
            owner_id      <= owner_n;
            grant         <= grant_n;
            rr_q          <= rr_n;
            susp_q        <= susp_n;
            hold_q        <= hold_n;
            nb_interrupts <= cnt_n;
            timeout_err   <= terr_n;
        end
    end

endmodule

// File: tb/tb_access_arbiter_param.sv
// Bench for access_arbiter_param: two instances share stimulus, one with an
// 8-bit interrupt counter and one with a 2-bit counter for saturation.
module tb_access_arbiter_param;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] req;
    logic [2:0] done;

    logic [2:0] grant_a, grant_b;
    logic [1:0] owner_a, owner_b;
    logic [1:0] state_a, state_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic       terr_a, terr_b;

    typedef struct packed {
        logic [2:0] g;
        logic [1:0] o;
        logic [1:0] s;
        logic [7:0] c;
        logic       t;
        logic [2:0] g2;
        logic [1:0] o2;
        logic [1:0] s2;
        logic [1:0] c2;
        logic       t2;
    } obs_t;

    typedef struct packed {
        logic       rst;
        logic [2:0] r;
        logic [2:0] d;
        obs_t       e;
    } vec_t;

    obs_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    access_arbiter_param #(.N_MASTERS(3), .CNT_W(8), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .grant(grant_a), .owner_id(owner_a), .state(state_a),
        .nb_interrupts(cnt_a), .timeout_err(terr_a)
    );

    access_arbiter_param #(.N_MASTERS(3), .CNT_W(2), .TIMEOUT(16)) dut_sat (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .grant(grant_b), .owner_id(owner_b), .state(state_b),
        .nb_interrupts(cnt_b), .timeout_err(terr_b)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000, required finish earlier");
        $fatal(1);
    end

    function automatic vec_t mk(input logic rst, input logic [2:0] r, input logic [2:0] d,
                                input logic [2:0] g, input logic [1:0] o, input logic [1:0] s,
                                input int c, input logic t);
        vec_t v;
        v.rst  = rst;
        v.r    = r;
        v.d    = d;
        v.e.g  = g;
        v.e.o  = o;
        v.e.s  = s;
        v.e.c  = 8'(c);
        v.e.t  = t;
        v.e.g2 = g;
        v.e.o2 = o;
        v.e.s2 = s;
        v.e.c2 = (c > 3) ? 2'd3 : 2'(c);
        v.e.t2 = t;
        return v;
    endfunction

    function automatic obs_t sample();
        obs_t x;
        x.g  = grant_a;  x.o  = owner_a; x.s  = state_a; x.c  = cnt_a; x.t  = terr_a;
        x.g2 = grant_b;  x.o2 = owner_b; x.s2 = state_b; x.c2 = cnt_b; x.t2 = terr_b;
        return x;
    endfunction

    function automatic string fmt(input obs_t x);
        return $sformatf("g=%b o=%0d s=%b c=%0d t=%b | g2=%b o2=%0d s2=%b c2=%0d t2=%b",
                         x.g, x.o, x.s, x.c, x.t, x.g2, x.o2, x.s2, x.c2, x.t2);
    endfunction

    task automatic apply(input vec_t v);
        reset = v.rst;
        req   = v.r;
        done  = v.d;
        exp_q.push_back(v.e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vec_t v[$];
        obs_t got, exp;
        v.push_back(mk(1, 3'b111, 3'b000, 3'b000, 0, 2'b00, 0, 0));
        v.push_back(mk(1, 3'b111, 3'b111, 3'b000, 0, 2'b00, 0, 0));
        v.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, 2'b00, 0, 0));
        v.push_back(mk(0, 3'b001, 3'b000, 3'b001, 0, 2'b01, 0, 0));
        v.push_back(mk(0, 3'b001, 3'b001, 3'b001, 0, 2'b01, 0, 0));
        v.push_back(mk(0, 3'b000, 3'b001, 3'b000, 0, 2'b00, 0, 0));
        foreach (v[i]) begin
            apply(v[i]);
            got = sample();
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) $display("FAIL reset[%0d] got %s required %s", i, fmt(got), fmt(exp));
            else passed++;
        end
    endtask

    task automatic test_grant_release();
        vec_t v[$];
        obs_t got, exp;
        v.push_back(mk(1, 3'b000, 3'b000, 3'b000, 0, 2'b00, 0, 0));
        v.push_back(mk(0, 3'b010, 3'b000, 3'b010, 1, 2'b01, 0, 0));
        v.push_back(mk(0, 3'b000, 3'b000, 3'b010, 1, 2'b01, 0, 0));
        v.push_back(mk(0, 3'b000, 3'b101, 3'b010, 1, 2'b01, 0, 0));
        v.push_back(mk(0, 3'b000, 3'b010, 3'b000, 0, 2'b00, 0, 0));
        v.push_back(mk(0, 3'b110, 3'b000, 3'b100, 2, 2'b01, 0, 0));
        v.push_back(mk(0, 3'b110, 3'b100, 3'b010, 1, 2'b01, 0, 0));
        v.push_back(mk(0, 3'b000, 3'b010, 3'b000, 0, 2'b00, 0, 0));
        foreach (v[i]) begin
            apply(v[i]);
            got = sample();
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) $display("FAIL grant_release[%0d] got %s required %s", i, fmt(got), fmt(exp));
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[$];
        obs_t got, exp;
        v.push_back(mk(1, 3'b000, 3'b000, 3'b000, 0, 2'b00, 0, 0));
        v.push_back(mk(0, 3'b110, 3'b000, 3'b010, 1, 2'b01, 0, 0));
        v.push_back(mk(0, 3'b110, 3'b010, 3'b100, 2, 2'b01, 0, 0));
        v.push_back(mk(0, 3'b111, 3'b100, 3'b001, 0, 2'b01, 0, 0));
        v.push_back(mk(0, 3'b000, 3'b001, 3'b000, 0, 2'b00, 0, 0));
        foreach (v[i]) begin
            apply(v[i]);
            got = sample();
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) $display("FAIL back_to_back[%0d] got %s required %s", i, fmt(got), fmt(exp));
            else passed++;
        end
    endtask

    task automatic test_preempt();
        vec_t v[$];
        obs_t got, exp;
        v.push_back(mk(1, 3'b000, 3'b000, 3'b000, 0, 2'b00, 0, 0));
        v.push_back(mk(0, 3'b010, 3'b000, 3'b010, 1, 2'b01, 0, 0));
        v.push_back(mk(0, 3'b011, 3'b000, 3'b001, 0, 2'b10, 1, 0));
        v.push_back(mk(0, 3'b011, 3'b000, 3'b001, 0, 2'b10, 1, 0));
        v.push_back(mk(0, 3'b010, 3'b001, 3'b010, 1, 2'b01, 1, 0));
        v.push_back(mk(0, 3'b011, 3'b010, 3'b001, 0, 2'b01, 1, 0));
        v.push_back(mk(0, 3'b000, 3'b001, 3'b000, 0, 2'b00, 1, 0));
        v.push_back(mk(0, 3'b010, 3'b000, 3'b010, 1, 2'b01, 1, 0));
        v.push_back(mk(0, 3'b011, 3'b000, 3'b001, 0, 2'b10, 2, 0));
        v.push_back(mk(0, 3'b100, 3'b001, 3'b100, 2, 2'b01, 2, 0));
        v.push_back(mk(0, 3'b101, 3'b000, 3'b001, 0, 2'b10, 3, 0));
        v.push_back(mk(0, 3'b001, 3'b001, 3'b000, 0, 2'b00, 3, 0));
        v.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, 2'b00, 3, 0));
        foreach (v[i]) begin
            apply(v[i]);
            got = sample();
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) $display("FAIL preempt[%0d] got %s required %s", i, fmt(got), fmt(exp));
            else passed++;
        end
    endtask

    task automatic test_timeout();
        vec_t v[$];
        obs_t got, exp;
        v.push_back(mk(1, 3'b000, 3'b000, 3'b000, 0, 2'b00, 0, 0));
        v.push_back(mk(0, 3'b100, 3'b000, 3'b100, 2, 2'b01, 0, 0));
        for (int k = 0; k < 15; k++) v.push_back(mk(0, 3'b100, 3'b000, 3'b100, 2, 2'b01, 0, 0));
        v.push_back(mk(0, 3'b100, 3'b000, 3'b000, 0, 2'b00, 0, 1));
        v.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, 2'b00, 0, 0));
        v.push_back(mk(0, 3'b010, 3'b000, 3'b010, 1, 2'b01, 0, 0));
        v.push_back(mk(0, 3'b011, 3'b000, 3'b001, 0, 2'b10, 1, 0));
        for (int k = 0; k < 15; k++) v.push_back(mk(0, 3'b011, 3'b000, 3'b001, 0, 2'b10, 1, 0));
        v.push_back(mk(0, 3'b011, 3'b000, 3'b000, 0, 2'b00, 1, 1));
        v.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, 2'b00, 1, 0));
        v.push_back(mk(0, 3'b100, 3'b000, 3'b100, 2, 2'b01, 1, 0));
        for (int k = 0; k < 15; k++) v.push_back(mk(0, 3'b100, 3'b000, 3'b100, 2, 2'b01, 1, 0));
        v.push_back(mk(0, 3'b000, 3'b100, 3'b000, 0, 2'b00, 1, 0));
        foreach (v[i]) begin
            apply(v[i]);
            got = sample();
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) $display("FAIL timeout[%0d] got %s required %s", i, fmt(got), fmt(exp));
            else passed++;
        end
    endtask

    task automatic test_saturation();
        vec_t v[$];
        obs_t got, exp;
        v.push_back(mk(1, 3'b000, 3'b000, 3'b000, 0, 2'b00, 0, 0));
        v.push_back(mk(0, 3'b010, 3'b000, 3'b010, 1, 2'b01, 0, 0));
        for (int n = 1; n <= 5; n++) begin
            v.push_back(mk(0, 3'b011, 3'b000, 3'b001, 0, 2'b10, n, 0));
            v.push_back(mk(0, 3'b010, 3'b001, 3'b010, 1, 2'b01, n, 0));
        end
        v.push_back(mk(0, 3'b010, 3'b000, 3'b010, 1, 2'b01, 5, 0));
        foreach (v[i]) begin
            apply(v[i]);
            got = sample();
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) $display("FAIL saturation[%0d] got %s required %s", i, fmt(got), fmt(exp));
            else passed++;
        end
    endtask

    task automatic test_reset_preempt();
        vec_t v[$];
        obs_t got, exp;
        v.push_back(mk(1, 3'b000, 3'b000, 3'b000, 0, 2'b00, 0, 0));
        v.push_back(mk(0, 3'b010, 3'b000, 3'b010, 1, 2'b01, 0, 0));
        v.push_back(mk(0, 3'b011, 3'b000, 3'b001, 0, 2'b10, 1, 0));
        v.push_back(mk(1, 3'b011, 3'b001, 3'b000, 0, 2'b00, 0, 0));
        v.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, 2'b00, 0, 0));
        v.push_back(mk(0, 3'b110, 3'b000, 3'b010, 1, 2'b01, 0, 0));
        v.push_back(mk(0, 3'b000, 3'b010, 3'b000, 0, 2'b00, 0, 0));
        foreach (v[i]) begin
            apply(v[i]);
            got = sample();
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) $display("FAIL reset_preempt[%0d] got %s required %s", i, fmt(got), fmt(exp));
            else passed++;
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        done  = '0;
        test_reset();
        test_grant_release();
        test_back_to_back();
        test_preempt();
        test_timeout();
        test_saturation();
        test_reset_preempt();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
